pdu_emptylist_mgr: RTL and testbench

Free-list manager for PDU buffer IDs. It sits directly upstream of the PDU data mover: it hands free PDU IDs to the PDU generator and takes back the IDs the data mover returns on its emptylist stream once a PDU's DRAM region is released. After reset it fills an internal circular ID queue with every ID, then serves allocations and frees concurrently at one per cycle each.

---
 rtl/pdu_emptylist_mgr.sv | 173 +++++++++++++++++
 tb/tb_pdu_emptylist_mgr.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdu_emptylist_mgr.sv
// pdu_emptylist_mgr: free-list manager for PDU buffer IDs (circular ID RAM + 2-entry prefetch).
// Define PDU_EMPTYLIST_CHECK_EN to enable the in-use bitmap and double-free detection.
module pdu_emptylist_mgr #(
    parameter int unsigned PDU_NUM  = 1024,
    parameter int unsigned PDU_ID_W = 10
) (
    input  logic                Clk,
    input  logic                Rst_n,
    output logic [PDU_ID_W-1:0] alloc_data,
    output logic                alloc_valid,
    input  logic                alloc_ready,
    input  logic [PDU_ID_W-1:0] free_data,
    input  logic                free_valid,
    output logic                free_ready,
    output logic [PDU_ID_W:0]   free_count,
    output logic                init_done,
    output logic                double_free_err
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [PDU_ID_W:0]   NUM     = {1'b1, {PDU_ID_W{1'b0}}};
    localparam logic [PDU_ID_W:0]   CNT_ONE = {{PDU_ID_W{1'b0}}, 1'b1};
    localparam logic [PDU_ID_W-1:0] PTR_ONE = {{(PDU_ID_W-1){1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [PDU_ID_W:0]   init_cnt;
    logic [PDU_ID_W-1:0] mem [0:PDU_NUM-1];
    logic [PDU_ID_W-1:0] wr_ptr, rd_ptr;
    logic [PDU_ID_W:0]   ram_count, ram_count_nxt;
    logic [PDU_ID_W:0]   free_count_nxt;
    logic                rd_inflight;
    logic [PDU_ID_W-1:0] ram_q;
    logic [PDU_ID_W-1:0] pf0, pf1;
    logic [1:0]          pf_count;
    logic [2:0]          pf_occ;

    logic                alloc_fire, free_fire, free_store, owned;
    logic                init_wr, rd_en, ram_we;
    logic [PDU_ID_W-1:0] ram_waddr, ram_wdata;

    assign alloc_valid = (pf_count != 2'd0);
    assign alloc_data  = pf0;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign free_fire   = free_valid && free_ready;
    assign free_store  = free_fire && owned;

    assign init_wr   = (state == ST_INIT) && !init_cnt[PDU_ID_W];
    assign ram_we    = init_wr || free_store;
    assign ram_waddr = init_wr ? init_cnt[PDU_ID_W-1:0] : wr_ptr;
    assign ram_wdata = init_wr ? init_cnt[PDU_ID_W-1:0] : free_data;

    // Prefetch occupancy counts the read in flight and credits a same-cycle pop.
    assign pf_occ = {1'b0, pf_count} + {2'b00, rd_inflight} - {2'b00, alloc_fire};
    assign rd_en  = (state == ST_RUN) && (ram_count != '0) && (pf_occ < 3'd2);

    always_comb begin
        state_nxt      = state;
        free_count_nxt = free_count;
        ram_count_nxt  = ram_count;
        case (state)
            ST_INIT: begin
                if (init_cnt[PDU_ID_W]) begin
                    state_nxt      = ST_RUN;
                    free_count_nxt = NUM;
                    ram_count_nxt  = NUM;
                end
            end
            ST_RUN: begin
                if (free_store && !alloc_fire)
                    free_count_nxt = free_count + CNT_ONE;
                else if (!free_store && alloc_fire)
                    free_count_nxt = free_count - CNT_ONE;
                if (free_store && !rd_en)
                    ram_count_nxt = ram_count + CNT_ONE;
                else if (!free_store && rd_en)
                    ram_count_nxt = ram_count - CNT_ONE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
        if (rd_en)
            ram_q <= mem[rd_ptr];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_count   <= '0;
            free_count  <= '0;
            free_ready  <= 1'b0;
            init_done   <= 1'b0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_nxt;
            ram_count   <= ram_count_nxt;
            free_count  <= free_count_nxt;
            free_ready  <= (state_nxt == ST_RUN) && (free_count_nxt != NUM);
            rd_inflight <= rd_en;
            if (init_wr)
                init_cnt <= init_cnt + CNT_ONE;
            if (state_nxt == ST_RUN)
                init_done <= 1'b1;
            if (free_store)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // pf0 is always the head; a load lands behind any entry that survives this cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pf0      <= '0;
            pf1      <= '0;
            pf_count <= '0;
        end else begin
            case ({rd_inflight, alloc_fire})
                2'b10: begin
                    if (pf_count == 2'd0)
                        pf0 <= ram_q;
                    else
                        pf1 <= ram_q;
                    pf_count <= pf_count + 2'd1;
                end
                2'b01: begin
                    pf0      <= pf1;
                    pf_count <= pf_count - 2'd1;
                end
                2'b11: begin
                    if (pf_count == 2'd1) begin
                        pf0 <= ram_q;
                    end else begin
                        pf0 <= pf1;
                        pf1 <= ram_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PDU_EMPTYLIST_CHECK_EN
    logic [PDU_NUM-1:0] in_use;

    assign owned = in_use[free_data];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            in_use          <= '0;
            double_free_err <= 1'b0;
        end else begin
            if (alloc_fire)
                in_use[alloc_data] <= 1'b1;
            if (free_store)
                in_use[free_data] <= 1'b0;
            if (free_fire && !owned)
                double_free_err <= 1'b1;
        end
    end
`else
    assign owned           = 1'b1;
    assign double_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_pdu_emptylist_mgr.sv
// Self-checking bench for pdu_emptylist_mgr (PDU_NUM=16): vector table, directed corner
// sequences and randomized traffic against a FIFO reference model of the free list.
module tb_pdu_emptylist_mgr;

    localparam int N = 16;
    localparam int W = 4;

    logic         Clk;
    logic         Rst_n;
    logic [W-1:0] alloc_data;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [W-1:0] free_data;
    logic         free_valid;
    logic         free_ready;
    logic [W:0]   free_count;
    logic         init_done;
    logic         double_free_err;

    pdu_emptylist_mgr #(.PDU_NUM(N), .PDU_ID_W(W)) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .alloc_data      (alloc_data),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .free_data       (free_data),
        .free_valid      (free_valid),
        .free_ready      (free_ready),
        .free_count      (free_count),
        .init_done       (init_done),
        .double_free_err (double_free_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: free list as a FIFO of {id, edge it entered}; an ID becomes
    // visible at the head two edges after it entered (RAM write, read, prefetch load).
    typedef struct {
        int id;
        int t;
    } ent_t;

    typedef struct {
        bit ar;
        bit fv;
        int fd;
        bit e_av;
        int e_ad;
        int e_fc;
    } vec_t;

    ent_t q[$];
    int   held[$];
    bit   m_owned[N];
    bit   m_init;
    bit   m_err;
    int   init_left;
    int   cyc;
    int   n_alloc;
    int   errors;
    int   checks;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all();
        int eav;
        eav = (q.size() > 0 && q[0].t + 2 <= cyc) ? 1 : 0;
        chk("free_count", int'(free_count), q.size());
        chk("alloc_valid", int'(alloc_valid), eav);
        if (eav == 1 && alloc_valid)
            chk("alloc_data", int'(alloc_data), q[0].id);
        chk("free_ready", int'(free_ready), (m_init && q.size() != N) ? 1 : 0);
        chk("init_done", int'(init_done), int'(m_init));
        chk("double_free_err", int'(double_free_err), int'(m_err));
    endtask

    task automatic cycle();
        bit afire, ffire, own_f;
        int aid, fid;
        afire = alloc_valid && alloc_ready;
        ffire = free_valid && free_ready;
        aid   = int'(alloc_data);
        fid   = int'(free_data);
        own_f = m_owned[fid];
        @(posedge Clk);
        cyc++;
        if (init_left > 0) begin
            init_left--;
            if (init_left == 0) begin
                m_init = 1'b1;
                for (int i = 0; i < N; i++) q.push_back('{id: i, t: cyc});
            end
        end
        if (afire) begin
            if (q.size() > 0) void'(q.pop_front());
            held.push_back(aid);
            m_owned[aid] = 1'b1;
            n_alloc++;
        end
        if (ffire) begin
            for (int i = 0; i < held.size(); i++)
                if (held[i] == fid) begin
                    held.delete(i);
                    break;
                end
`ifdef PDU_EMPTYLIST_CHECK_EN
            if (own_f) begin
                q.push_back('{id: fid, t: cyc});
                m_owned[fid] = 1'b0;
            end else begin
                m_err = 1'b1;
            end
`else
            q.push_back('{id: fid, t: cyc});
            m_owned[fid] = 1'b0;
`endif
        end
        @(negedge Clk);
        check_all();
    endtask

    task automatic do_reset();
        #2 Rst_n = 1'b0;
        #1;
        q.delete();
        held.delete();
        for (int i = 0; i < N; i++) m_owned[i] = 1'b0;
        m_init    = 1'b0;
        m_err     = 1'b0;
        init_left = 0;
        chk("rst_alloc_valid", int'(alloc_valid), 0);
        chk("rst_alloc_data", int'(alloc_data), 0);
        chk("rst_free_ready", int'(free_ready), 0);
        chk("rst_free_count", int'(free_count), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_double_free_err", int'(double_free_err), 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n     = 1'b1;
        init_left = N + 1;
    endtask

    task automatic drain_and_score();
        int guard;
        int dups;
        bit seen[N];
        guard       = 0;
        alloc_ready = 1'b1;
        free_valid  = 1'b0;
        while (q.size() > 0 && guard < 64) begin
            cycle();
            guard++;
        end
        chk("drain_left", q.size(), 0);
        chk("drain_av", int'(alloc_valid), 0);
        dups = 0;
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        foreach (held[i]) begin
            if (seen[held[i]]) dups++;
            seen[held[i]] = 1'b1;
        end
        chk("sb_held", held.size(), N);
        chk("sb_dups", dups, 0);
    endtask

    vec_t tbl[10];

    initial begin
        int base;
        int guard;
        int hold_id;

        tbl[0] = '{ar: 1, fv: 1, fd: 5, e_av: 0, e_ad: 0, e_fc: 1};
        tbl[1] = '{ar: 1, fv: 0, fd: 0, e_av: 0, e_ad: 0, e_fc: 1};
        tbl[2] = '{ar: 1, fv: 0, fd: 0, e_av: 1, e_ad: 5, e_fc: 1};
        tbl[3] = '{ar: 1, fv: 0, fd: 0, e_av: 0, e_ad: 0, e_fc: 0};
        tbl[4] = '{ar: 0, fv: 1, fd: 9, e_av: 0, e_ad: 0, e_fc: 1};
        tbl[5] = '{ar: 0, fv: 1, fd: 3, e_av: 0, e_ad: 0, e_fc: 2};
        tbl[6] = '{ar: 0, fv: 0, fd: 0, e_av: 1, e_ad: 9, e_fc: 2};
        tbl[7] = '{ar: 0, fv: 0, fd: 0, e_av: 1, e_ad: 9, e_fc: 2};
        tbl[8] = '{ar: 1, fv: 0, fd: 0, e_av: 1, e_ad: 3, e_fc: 1};
        tbl[9] = '{ar: 1, fv: 0, fd: 0, e_av: 0, e_ad: 0, e_fc: 0};

        errors      = 0;
        checks      = 0;
        cyc         = 0;
        n_alloc     = 0;
        Rst_n       = 1'b1;
        alloc_ready = 1'b1;
        free_valid  = 1'b0;
        free_data   = '0;

        // Init fill, then 0..15 on consecutive cycles; a free at full list is refused.
        do_reset();
        for (int i = 0; i < N; i++) cycle();
        chk("init_done_early", int'(init_done), 0);
        free_valid = 1'b1;
        free_data  = 4'd7;
        cycle();
        chk("init_done_rise", int'(init_done), 1);
        chk("init_fc", int'(free_count), N);
        chk("full_free_ready", int'(free_ready), 0);
        cycle();
        free_valid = 1'b0;
        chk("full_fc_hold", int'(free_count), N);
        chk("av_one_after", int'(alloc_valid), 0);
        cycle();
        for (int k = 0; k < N; k++) begin
            chk("init_seq_valid", int'(alloc_valid), 1);
            chk("init_seq_data", int'(alloc_data), k);
            cycle();
        end
        chk("empty_av", int'(alloc_valid), 0);
        chk("empty_fc", int'(free_count), 0);

        // Free into the empty list and a short backpressured pair, from the vector table.
        for (int i = 0; i < 10; i++) begin
            alloc_ready = tbl[i].ar;
            free_valid  = tbl[i].fv;
            free_data   = W'(tbl[i].fd);
            cycle();
            chk("tbl_fc", int'(free_count), tbl[i].e_fc);
            chk("tbl_av", int'(alloc_valid), int'(tbl[i].e_av));
            if (tbl[i].e_av)
                chk("tbl_ad", int'(alloc_data), tbl[i].e_ad);
        end
        free_valid = 1'b0;

        // Steady alloc/free for 100 cycles with four IDs in the list.
        alloc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            free_valid = 1'b1;
            free_data  = W'(held[0]);
            cycle();
        end
        free_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 100; i++) begin
            alloc_ready = 1'b1;
            free_valid  = 1'b1;
            free_data   = W'(held[0]);
            cycle();
            chk("steady_fc", int'(free_count), 4);
        end
        free_valid  = 1'b0;
        alloc_ready = 1'b0;

        // Backpressure: head held stable for 10 cycles, then drain and scoreboard.
        cycle();
        hold_id = q[0].id;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", int'(alloc_valid), 1);
            chk("bp_data", int'(alloc_data), hold_id);
            cycle();
        end
        drain_and_score();

        // Randomized traffic, frees drawn from the IDs currently held by the consumer.
        for (int i = 0; i < 400; i++) begin
            alloc_ready = ($urandom % 4) != 0;
            if (held.size() > 0 && ($urandom % 3) != 0) begin
                free_valid = 1'b1;
                free_data  = W'(held[$urandom_range(0, held.size() - 1)]);
            end else begin
                free_valid = 1'b0;
            end
            cycle();
        end
        drain_and_score();

        // Reset mid-RUN after 5 allocations; allocation restarts at ID 0.
        alloc_ready = 1'b1;
        do_reset();
        base  = n_alloc;
        guard = 0;
        while (n_alloc < base + 5 && guard < 40) begin
            cycle();
            guard++;
        end
        chk("five_allocs", n_alloc - base, 5);
        alloc_ready = 1'b0;
        do_reset();
        for (int i = 0; i < N + 3; i++) cycle();
        chk("rerun_av", int'(alloc_valid), 1);
        chk("rerun_first", int'(alloc_data), 0);

        // Free of an unallocated ID (7) while three IDs are out.
        alloc_ready = 1'b1;
        base  = n_alloc;
        guard = 0;
        while (n_alloc < base + 3 && guard < 20) begin
            cycle();
            guard++;
        end
        alloc_ready = 1'b0;
        chk("pre_illegal_fc", int'(free_count), N - 3);
        free_valid = 1'b1;
        free_data  = 4'd7;
        chk("illegal_free_ready", int'(free_ready), 1);
        cycle();
        free_valid = 1'b0;
`ifdef PDU_EMPTYLIST_CHECK_EN
        chk("illegal_err", int'(double_free_err), 1);
        chk("illegal_fc", int'(free_count), N - 3);
`else
        chk("illegal_err", int'(double_free_err), 0);
        chk("illegal_fc", int'(free_count), N - 2);
`endif
        free_valid = 1'b1;
        free_data  = W'(held[0]);
        cycle();
        free_valid = 1'b0;
`ifdef PDU_EMPTYLIST_CHECK_EN
        chk("err_sticky", int'(double_free_err), 1);
        chk("legal_fc", int'(free_count), N - 2);
`else
        chk("err_sticky", int'(double_free_err), 0);
        chk("legal_fc", int'(free_count), N - 1);
`endif
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
